// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter, its ALU core and bench.
package alu_arb_pkg;

    localparam int unsigned W_DEF       = 4;
    localparam int unsigned OP_W_DEF    = 3;
    localparam int unsigned ALU_LAT_DEF = 2;
    localparam int unsigned CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Opcode encodings understood by the ALU core
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to ptr.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || !ptr)) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one gated ALU between two valid/ready requesters, one transaction in flight.
// Optional per-requester saturating grant counters when ARB_STATS_EN is defined.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned W       = W_DEF,
    parameter int unsigned OP_W    = OP_W_DEF,
    parameter int unsigned ALU_LAT = ALU_LAT_DEF
`ifdef ARB_STATS_EN
    ,
    parameter int unsigned CNT_W   = CNT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*W-1:0]    req_a,
    input  logic [2*W-1:0]    req_b,
    input  logic [2*OP_W-1:0] req_op,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic              alu_en,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [W-1:0]      alu_result
`ifdef ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
`endif
);

    localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_e        state_q, state_d;
    logic [1:0]    gnt;
    logic          ptr_q;
    logic          id_q;
    logic [CW-1:0] cnt_q;
    logic          req_hs;
    logic          exec_done;
    logic          rsp_hs;

    rr_arb2 u_rr_arb2 (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the combinational accept; no grants are offered while in reset
    always_comb begin
        state_d   = state_q;
        req_ready = 2'b00;
        req_hs    = 1'b0;
        exec_done = 1'b0;
        rsp_hs    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_n && (gnt != 2'b00)) begin
                    req_ready = gnt;
                    req_hs    = 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                exec_done = (cnt_q == '0);
                if (exec_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_hs = rsp_ready[id_q];
                if (rsp_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, execute window and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q     <= 1'b0;
            id_q      <= 1'b0;
            cnt_q     <= '0;
            alu_en    <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            rsp_valid <= 2'b00;
            rsp_data  <= '0;
        end else begin
            if (req_hs) begin
                id_q   <= gnt[1];
                ptr_q  <= ~gnt[1];
                cnt_q  <= CW'(ALU_LAT - 1);
                alu_en <= 1'b1;
                alu_a  <= gnt[1] ? req_a[2*W-1:W]       : req_a[W-1:0];
                alu_b  <= gnt[1] ? req_b[2*W-1:W]       : req_b[W-1:0];
                alu_op <= gnt[1] ? req_op[2*OP_W-1:OP_W] : req_op[OP_W-1:0];
            end else if (state_q == EXEC) begin
                if (exec_done) begin
                    alu_en    <= 1'b0;
                    alu_a     <= '0;
                    alu_b     <= '0;
                    alu_op    <= '0;
                    rsp_data  <= alu_result;
                    rsp_valid <= id_q ? 2'b10 : 2'b01;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
            if (rsp_hs) begin
                rsp_valid <= 2'b00;
            end
        end
    end

`ifdef ARB_STATS_EN
    // Saturating grant counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (req_hs) begin
            if (gnt[1]) begin
                if (grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end else begin
                if (grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: vector table, scoreboard and directed corner cases.
module tb_alu_req_arbiter;
    import alu_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_a, req_b;
    logic [5:0]  req_op;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [3:0]  rsp_data;
    logic        alu_en;
    logic [3:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [3:0]  alu_result;
`ifdef ARB_STATS_EN
    logic [1:0]  gc0, gc1;
`endif

    logic [3:0]  pa [2];
    logic [3:0]  pb [2];
    logic [2:0]  pop [2];
    logic [3:0]  cur_exp [2];

    assign req_a  = {pa[1], pa[0]};
    assign req_b  = {pb[1], pb[0]};
    assign req_op = {pop[1], pop[0]};

    typedef struct packed {
        logic       id;
        logic [3:0] data;
    } exp_t;

    typedef struct {
        logic       id;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] exp;
    } vec_t;

    exp_t sb [$];
    int   hs_cyc [$];
    int   hs_id [$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl [7];

    alu_req_arbiter #(
        .W       (4),
        .OP_W    (3),
        .ALU_LAT (2)
`ifdef ARB_STATS_EN
        ,
        .CNT_W   (2)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .alu_en     (alu_en),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt0 (gc0),
        .grant_cnt1 (gc1)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU core behind the operand gate
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            default: alu_result = 4'h0;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: push on request handshake, pop and compare on response handshake
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{id: 1'(i), data: cur_exp[i]});
                    hs_cyc.push_back(cyc);
                    hs_id.push_back(i);
                end
            end
            if ((rsp_valid & rsp_ready) != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_valid), e.id ? 32'h2 : 32'h1);
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic id, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input logic [3:0] e);
        bit ok;
        ok = 1'b0;
        pa[id] = a; pb[id] = b; pop[id] = op; cur_exp[id] = e;
        req_valid[id] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            at_neg();
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("issue_timeout", 32'h0, 32'h1);
        tick();
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            at_neg();
            if (sb.size() == 0 && rsp_valid == 2'b00 && alu_en == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'h0, 32'h1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 4'h3, 4'h4, OP_ADD, 4'h7};
        tbl[1] = '{1'b1, 4'hF, 4'h1, OP_ADD, 4'h0};
        tbl[2] = '{1'b1, 4'hA, 4'h5, OP_OR,  4'hF};
        tbl[3] = '{1'b0, 4'hC, 4'hA, OP_XOR, 4'h6};
        tbl[4] = '{1'b1, 4'h2, 4'h5, OP_SUB, 4'hD};
        tbl[5] = '{1'b0, 4'hF, 4'hF, OP_AND, 4'hF};
        tbl[6] = '{1'b1, 4'h9, 4'h6, OP_AND, 4'h0};

        // Reset held with both requesters valid
        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            pa[i] = 4'h5; pb[i] = 4'h6; pop[i] = OP_OR; cur_exp[i] = 4'h7;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_req_ready", 32'(req_ready), 32'h0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("rst_alu_en", 32'(alu_en), 32'h0);
            chk("rst_alu_a", 32'(alu_a), 32'h0);
            chk("rst_alu_b", 32'(alu_b), 32'h0);
            chk("rst_alu_op", 32'(alu_op), 32'h0);
            chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        end
        tick();
        rst_n = 1'b1;
        req_valid = 2'b00;

        // Single AND transaction with cycle-exact timing
        tick();
        pa[0] = 4'b1010; pb[0] = 4'b1100; pop[0] = OP_AND; cur_exp[0] = 4'b1000;
        req_valid = 2'b01;
        at_neg();
        chk("t2_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        at_neg();
        chk("t2_en1", 32'(alu_en), 32'h1);
        chk("t2_alu_a", 32'(alu_a), 32'hA);
        chk("t2_alu_b", 32'(alu_b), 32'hC);
        chk("t2_alu_op", 32'(alu_op), 32'(OP_AND));
        chk("t2_busy_ready", 32'(req_ready), 32'h0);
        tick();
        at_neg();
        chk("t2_en2", 32'(alu_en), 32'h1);
        chk("t2_no_rsp_yet", 32'(rsp_valid), 32'h0);
        tick();
        at_neg();
        chk("t2_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t2_rsp_data", 32'(rsp_data), 32'h8);
        chk("t2_en_off", 32'(alu_en), 32'h0);
        chk("t2_alu_a_off", 32'(alu_a), 32'h0);
        tick();
        at_neg();
        chk("t2_rsp_cleared", 32'(rsp_valid), 32'h0);
        tick();

        // Vector table, one transaction at a time
        foreach (tbl[i]) begin
            issue(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp);
            drain();
        end

        // Both valid continuously after reset: alternating grants, 4-cycle spacing
        rst_n = 1'b0;
        pa[0] = 4'h6; pb[0] = 4'h3; pop[0] = OP_OR;  cur_exp[0] = 4'h7;
        pa[1] = 4'h9; pb[1] = 4'h4; pop[1] = OP_ADD; cur_exp[1] = 4'hD;
        req_valid = 2'b11;
        tick();
        tick();
        hs_cyc.delete();
        hs_id.delete();
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            at_neg();
            if (hs_id.size() >= 4) break;
        end
        tick();
        req_valid = 2'b00;
        chk("t3_grants", 32'(hs_id.size()), 32'd4);
        if (hs_id.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("t3_order", 32'(hs_id[k]), 32'(k % 2));
                if (k > 0) chk("t3_spacing", 32'(hs_cyc[k] - hs_cyc[k-1]), 32'd4);
            end
        end
        drain();

        // Response back-pressure with req1 waiting
        rsp_ready = 2'b00;
        pa[0] = 4'h5; pb[0] = 4'h3; pop[0] = OP_XOR; cur_exp[0] = 4'h6;
        pa[1] = 4'h7; pb[1] = 4'h2; pop[1] = OP_SUB; cur_exp[1] = 4'h5;
        req_valid = 2'b11;
        at_neg();
        chk("t4_grant0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b10;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            at_neg();
            chk("t4_hold_valid", 32'(rsp_valid), 32'h1);
            chk("t4_hold_data", 32'(rsp_data), 32'h6);
            chk("t4_hold_ready", 32'(req_ready), 32'h0);
            tick();
        end
        rsp_ready = 2'b10;
        at_neg();
        chk("t4_ignore_other", 32'(rsp_valid), 32'h1);
        tick();
        rsp_ready = 2'b01;
        at_neg();
        chk("t4_resp_ready", 32'(req_ready), 32'h0);
        tick();
        at_neg();
        chk("t4_grant1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        drain();

        // Reset during the execute window drops the transaction
        pa[0] = 4'h3; pb[0] = 4'h3; pop[0] = OP_ADD; cur_exp[0] = 4'h6;
        req_valid = 2'b01;
        at_neg();
        chk("t5_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        rst_n = 1'b0;
        at_neg();
        chk("t5_en_before", 32'(alu_en), 32'h1);
        tick();
        rst_n = 1'b1;
        at_neg();
        chk("t5_en_after", 32'(alu_en), 32'h0);
        chk("t5_alu_a_after", 32'(alu_a), 32'h0);
        sb.delete();
        for (int k = 0; k < 6; k++) begin
            chk("t5_no_rsp", 32'(rsp_valid), 32'h0);
            at_neg();
        end
        tick();

`ifdef ARB_STATS_EN
        // Grant counters with saturation
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin issue(1'b0, 4'h1, 4'h1, OP_ADD, 4'h2); drain(); end
        for (int k = 0; k < 2; k++) begin issue(1'b1, 4'h1, 4'h2, OP_OR, 4'h3); drain(); end
        at_neg();
        chk("t6_cnt0", 32'(gc0), 32'd3);
        chk("t6_cnt1", 32'(gc1), 32'd2);
        tick();
        for (int k = 0; k < 2; k++) begin issue(1'b1, 4'h1, 4'h2, OP_OR, 4'h3); drain(); end
        at_neg();
        chk("t6_cnt1_sat", 32'(gc1), 32'd3);
        chk("t6_cnt0_hold", 32'(gc0), 32'd3);
        tick();
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
